// File: rtl/divider_pkg.sv
// divider_pkg: state type and sizing helpers shared by the iterative divider.
package divider_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   function automatic int iters(input int w, input int b);
      return (b > 0) ? w / b : 1;
   endfunction

   function automatic bit bpc_ok(input int w, input int b);
      return (b > 0) && (b <= w) && (w % b == 0);
   endfunction

endpackage

// File: rtl/divu_step.sv
// divu_step: one restoring division step; the shifted remainder is kept at WIDTH+1 bits so it cannot overflow.
module divu_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH:0] sh;
   logic [WIDTH:0] diff;
   logic           ge;

   assign sh    = {rem_i, q_i[WIDTH-1]};
   assign diff  = sh - {1'b0, divisor_i};
   assign ge    = sh >= {1'b0, divisor_i};
   assign rem_o = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
   assign q_o   = {q_i[WIDTH-2:0], ge};

endmodule

// File: rtl/divider_unsigned_iter.sv
// divider_unsigned_iter: iterative restoring unsigned divider, BITS_PER_CYCLE steps per clock.
// Define DIVIDER_FASTPATH_EN to finish divide-by-zero and dividend<divisor at the accepting edge.
module divider_unsigned_iter
   import divider_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder
);

   localparam int ITERS = iters(WIDTH, BITS_PER_CYCLE);
   localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

   if (!bpc_ok(WIDTH, BITS_PER_CYCLE)) begin : g_bad_cfg
      $error("BITS_PER_CYCLE must divide WIDTH");
   end

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;

   // Each stage lives in its own generate scope so the chain is not one self-referencing array.
   for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
      logic [WIDTH-1:0] r, q;
      if (i == 0) begin : g_first
         divu_step #(.WIDTH(WIDTH)) u_step (
            .rem_i(rem_q), .q_i(quo_q), .divisor_i(dvs_q), .rem_o(r), .q_o(q)
         );
      end else begin : g_next
         divu_step #(.WIDTH(WIDTH)) u_step (
            .rem_i(g_step[i-1].r), .q_i(g_step[i-1].q), .divisor_i(dvs_q), .rem_o(r), .q_o(q)
         );
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      case (state_q)
         IDLE: if (in_valid) begin
            state_d = BUSY;
            cnt_d   = '0;
            quo_d   = i_dividend;
            rem_d   = '0;
            dvs_d   = i_divisor;
`ifdef DIVIDER_FASTPATH_EN
            if (i_divisor == '0 || i_dividend < i_divisor) begin
               state_d = DONE;
               quo_d   = (i_divisor == '0) ? '1 : '0;
               rem_d   = i_dividend;
            end
`endif
         end
         BUSY: begin
            quo_d   = g_step[BITS_PER_CYCLE-1].q;
            rem_d   = g_step[BITS_PER_CYCLE-1].r;
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(ITERS - 1)) ? DONE : BUSY;
         end
         DONE:    state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign o_quotient  = quo_q;
   assign o_remainder = rem_q;

endmodule

// File: tb/tb_divider_unsigned_iter.sv
// tb_divider_unsigned_iter: directed and back-to-back checks of the divider against a / and % model.
module tb_divider_unsigned_iter;

   localparam int W   = 32;
   localparam int IT  = W / 4;
   localparam int IT1 = W;
`ifdef DIVIDER_FASTPATH_EN
   localparam bit FP = 1'b1;
`else
   localparam bit FP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0, out_ready = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b0;
   logic [W-1:0]  dvd = '0, dvs = '0;
   logic          in_ready, out_valid, in_ready1, out_valid1;
   logic [W-1:0]  quo, rem, quo1, rem1;

   int            total = 0;
   int            bad = 0;
   logic [63:0]   sb[$], sb1[$];
   int            lq[$], lq1[$];

   always #5 clk = ~clk;

   divider_unsigned_iter #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .i_dividend(dvd), .i_divisor(dvs), .out_valid(out_valid), .out_ready(out_ready),
      .o_quotient(quo), .o_remainder(rem)
   );

   divider_unsigned_iter #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .i_dividend(dvd), .i_divisor(dvs), .out_valid(out_valid1), .out_ready(out_ready1),
      .o_quotient(quo1), .o_remainder(rem1)
   );

   function automatic logic [63:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
      return (b == '0) ? {32'hFFFF_FFFF, a} : {a / b, a % b};
   endfunction

   function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b, input int it);
      return (FP && (b == '0 || a < b)) ? 0 : it;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
      logic [63:0] e;
      int n;
      chk("idle_ready", 64'(in_ready), 64'(1));
      dvd = a;
      dvs = b;
      in_valid = 1'b1;
      sb.push_back(ref_div(a, b));
      step();
      in_valid = 1'b0;
      dvd = 32'hDEAD_BEEF;
      dvs = 32'h0000_0003;
      chk("busy_ready", 64'(in_ready), 64'(0));
      n = 0;
      while (!out_valid && n < 100) begin
         step();
         n++;
      end
      chk("latency", 64'(n), 64'(exp_lat(a, b, IT)));
      e = sb.pop_front();
      chk("result", {quo, rem}, e);
      repeat (hold) begin
         step();
         chk("hold_valid", 64'({out_valid, in_ready}), 64'(2'b10));
         chk("hold_result", {quo, rem}, e);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("released", 64'({out_valid, in_ready}), 64'(2'b01));
   endtask

   initial begin
      logic [63:0] e;
      int l, last, last1, cnt0, cnt1;
      bit seen;
      #1;
      chk("rst_flags", 64'({out_valid, in_ready}), 64'(2'b01));
      chk("rst_result", {quo, rem}, 64'(0));
      step();
      step();
      rst_n = 1'b1;
      op(32'd100, 32'd7, 0);
      op(32'hFFFF_FFFF, 32'd1, 0);
      op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      op(32'hFFFF_FFFE, 32'h8000_0001, 0);
      op(32'd1234, 32'd0, 0);
      op(32'd5, 32'd9, 0);
      op(32'd100000, 32'd3, 5);
      // Abandon an operation three cycles in; nothing may come out afterwards.
      dvd = 32'd100;
      dvs = 32'd7;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      #1;
      chk("midrst_flags", 64'({out_valid, in_ready}), 64'(2'b01));
      chk("midrst_result", {quo, rem}, 64'(0));
      step();
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         step();
         seen |= out_valid;
      end
      chk("midrst_no_out", 64'(seen), 64'(0));
      op(32'd77, 32'd7, 0);
      in_valid = 1'b1;
      out_ready = 1'b1;
      in_valid1 = 1'b1;
      out_ready1 = 1'b1;
      last = -1;
      last1 = -1;
      cnt0 = 0;
      cnt1 = 0;
      for (int c = 0; c < 120; c++) begin
         dvd = $urandom;
         dvs = (c % 5 == 0) ? 32'd0 : (c % 5 == 1) ? $urandom_range(1, 50) : $urandom;
         if (out_valid) begin
            if (sb.size() == 0) chk("b2b4_spurious", 64'(out_valid), 64'(0));
            else begin
               e = sb.pop_front();
               l = lq.pop_front();
               chk("b2b4_result", {quo, rem}, e);
               if (last >= 0) chk("b2b4_interval", 64'(c - last), 64'(l + 2));
               last = c;
               cnt0++;
            end
         end
         if (in_ready) begin
            sb.push_back(ref_div(dvd, dvs));
            lq.push_back(exp_lat(dvd, dvs, IT));
         end
         if (out_valid1) begin
            if (sb1.size() == 0) chk("b2b1_spurious", 64'(out_valid1), 64'(0));
            else begin
               e = sb1.pop_front();
               l = lq1.pop_front();
               chk("b2b1_result", {quo1, rem1}, e);
               if (last1 >= 0) chk("b2b1_interval", 64'(c - last1), 64'(l + 2));
               last1 = c;
               cnt1++;
            end
         end
         if (in_ready1) begin
            sb1.push_back(ref_div(dvd, dvs));
            lq1.push_back(exp_lat(dvd, dvs, IT1));
         end
         step();
      end
      in_valid = 1'b0;
      in_valid1 = 1'b0;
      chk("b2b4_count", 64'(cnt0 >= 10), 64'(1));
      chk("b2b1_count", 64'(cnt1 >= 3), 64'(1));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
